mem_lane_ctrl: RTL and testbench
================================

# mem_lane_ctrl

Memory request controller directly downstream of the multi-cycle `criscv` core. It accepts the core's held-level request (address, size, rw, write data) and executes it against a 32-bit synchronous single-port SRAM with byte-lane enables. It also hosts the memory-mapped `port` output register. It returns right-justified read data and a `data_valid` handshake that the core polls in its fetch, load and store wait states.

## Interface
Parameters:
- `ADDR_W`, default 11: SRAM word-address width; 2^11 words = 8 KB, covering the stack top at 0x1FFC.
- `PORT_ADDR`, default 32'h0000_2000: byte address of the port register, word-aligned.

Ports:
- `mclk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-low; clock mclk
- `rw_req`  in  1  request; held high by the core until it sees `data_valid`
- `rw`  in  1  0 = read, 1 = write
- `address`  in  32  byte address
- `size`  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal
- `write_data`  in  32  store data, right-justified
- `read_data`  out  32  load data, right-justified, zero-extended
- `data_valid`  out  1  access complete
- `err`  out  1  misaligned/illegal access flag, valid while `data_valid`=1
- `port`  out  1  memory-mapped output bit
- `ram_addr`  out  ADDR_W  SRAM word address
- `ram_en`  out  1  SRAM access enable
- `ram_we`  out  4  SRAM byte write enables
- `ram_wdata`  out  32  SRAM write data, lane-shifted
- `ram_rdata`  in  32  SRAM read data; valid one cycle after `ram_en` is sampled

## Operation
- States: IDLE, RD_WAIT, RD_CAP, WR, DONE.
- IDLE, `rw_req`=1: latch `address[1:0]`, `size`, `rw`. Then decode:
  - Misaligned: half at offset 3, word at offset ≠0, or `size`=3. Set `err`=1, `read_data`=0, no RAM or port access, go to DONE.
  - Port hit: `address[31:2]`==`PORT_ADDR[31:2]`.
    - Write: `port` <= `write_data[0]`.
    - Read: `read_data` <= {31'b0, `port`}.
    - Go to DONE.
  - Out of range: `address` ≥ 4·2^ADDR_W and not a port hit. Reads return 0, writes are dropped, `err`=0, go to DONE.
  - Read: `ram_en`=1, `ram_addr`=`address[ADDR_W+1:2]`, go to RD_WAIT.
  - Write: `ram_en`=1, `ram_we` = lane mask, `ram_wdata` = `write_data` shifted left by 8·offset, go to WR.
- Lane masks:
  - byte: 0001 << offset
  - half: 0011 << offset
  - word: 1111
- RD_WAIT → RD_CAP. `ram_en` drops to 0.
- RD_CAP: `read_data` <= (`ram_rdata` >> 8·offset), masked to 8/16/32 bits. Go to DONE.
- WR: `ram_en`, `ram_we` <= 0. Go to DONE.
- DONE: `data_valid`=1. `read_data` and `err` are held stable. Stay until `rw_req`=0 is sampled, then clear `data_valid` and `err` and go to IDLE.
- A new request is accepted only from IDLE. A request held high across DONE is never re-executed.

## Timing
- Request sampled at edge N (IDLE).
- Read:
  - `ram_en` high after edge N.
  - RAM samples at N+1.
  - Data captured at N+2.
  - `data_valid` high after N+2. Latency 3 edges.
- Write: `ram_we` high for exactly one cycle (after N). `data_valid` high after N+2.
- Port, misaligned and out-of-range accesses: `data_valid` high after edge N+1, via a one-cycle pass through DONE's entry.
- Deassertion: the core drops `rw_req` one cycle after seeing `data_valid`. `data_valid` falls on the edge that samples `rw_req`=0. The earliest next request is accepted one edge later.
- Reset (`reset`=0 at an edge):
  - All outputs go to 0, including `port`, `ram_we`, `ram_en` and `data_valid`. State goes to IDLE.
  - A reset mid-write must deassert `ram_we` on that same edge.
  - No partial access completes after reset.
- No combinational path from inputs to outputs. All outputs are registered.

## Structure
- Shared package `mem_pkg`:
  - size encodings `SZ_BYTE`=0, `SZ_HALF`=1, `SZ_WORD`=2.
  - state enum.
  - default `PORT_ADDR`.
  - The core's memory request stage uses the same size constants.
- One sub-module, `lane_align`: purely combinational.
  - Store direction: offset/size → byte mask and shifted write data.
  - Load direction: read word → right-justified, masked data.

## Test plan
- LW at 0x0000_0010, RAM word 0xDEADBEEF → `ram_addr`=4, `read_data`=0xDEADBEEF, `data_valid` after 3 edges, `err`=0.
- SB 0xAB at 0x0000_0013 → `ram_we`=1000 for one cycle, `ram_wdata[31:24]`=0xAB. A following LBU at 0x13 returns 0x000000AB.
- LH at 0x0000_0002 over word 0x1234_5678 → 0x0000_1234. SH at offset 3 → `err`=1, `ram_we` never asserted.
- SW 0x1 to 0x0000_2000 → `port`=1, no RAM enable. LW from 0x2000 returns 0x00000001.
- `rw_req` held high for 5 cycles after `data_valid` → exactly one RAM access. `data_valid` stays high until `rw_req`=0.
- `reset`=0 in WR with `ram_we`=1111 → `ram_we`=0 on that edge. `port`=0, `data_valid`=0, and IDLE on release.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the core's memory request path: size encodings,
// controller state enum and the default port register address.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [31:0] DEFAULT_PORT_ADDR = 32'h0000_2000;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_CAP,
    WR,
    DONE
  } state_t;

  // Half may straddle lanes 1-2 but not run off the word; size 3 is never legal.
  function automatic logic is_misaligned(input logic [1:0] offset, input logic [1:0] sz);
    logic bad;
    bad = 1'b0;
    case (sz)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = (offset == 2'd3);
      SZ_WORD: bad = (offset != 2'd0);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lane_align.sv
// Combinational byte-lane steering between right-justified core data and
// the 32-bit SRAM word, in both store and load directions.
module lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  byte_mask,
  output logic [31:0] store_lanes,
  output logic [31:0] load_data
);

  logic [31:0] load_shifted;

  always_comb begin
    byte_mask    = 4'b1111;
    store_lanes  = store_data << {offset, 3'b000};
    load_shifted = load_word >> {offset, 3'b000};
    load_data    = load_shifted;
    case (size)
      SZ_BYTE: begin
        byte_mask = 4'b0001 << offset;
        load_data = {24'b0, load_shifted[7:0]};
      end
      SZ_HALF: begin
        byte_mask = 4'b0011 << offset;
        load_data = {16'b0, load_shifted[15:0]};
      end
      default: begin
        byte_mask = 4'b1111;
        load_data = load_shifted;
      end
    endcase
  end

endmodule

// File: rtl/mem_lane_ctrl.sv
// Executes the core's held-level memory request against a byte-enabled
// synchronous SRAM and hosts the memory-mapped port bit.
module mem_lane_ctrl
  import mem_pkg::*;
#(
  parameter int          ADDR_W    = 11,
  parameter logic [31:0] PORT_ADDR = DEFAULT_PORT_ADDR
) (
  input  logic              mclk,
  input  logic              reset,
  input  logic              rw_req,
  input  logic              rw,
  input  logic [31:0]       address,
  input  logic [1:0]        size,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  output logic              data_valid,
  output logic              err,
  output logic              port,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  state_t      state;
  logic [1:0]  off_reg;
  logic [1:0]  size_reg;

  logic [1:0]  align_off;
  logic [1:0]  align_size;
  logic [3:0]  align_mask;
  logic [31:0] align_wdata;
  logic [31:0] align_rdata;
  logic        port_hit;
  logic        out_of_range;

  // Store steering uses the live request in IDLE; load steering uses the latched one.
  assign align_off    = (state == IDLE) ? address[1:0] : off_reg;
  assign align_size   = (state == IDLE) ? size : size_reg;
  assign port_hit     = (address[31:2] == PORT_ADDR[31:2]);
  assign out_of_range = |address[31:ADDR_W+2];

  lane_align u_lane_align (
    .offset      (align_off),
    .size        (align_size),
    .store_data  (write_data),
    .load_word   (ram_rdata),
    .byte_mask   (align_mask),
    .store_lanes (align_wdata),
    .load_data   (align_rdata)
  );

  always_ff @(posedge mclk) begin
    if (!reset) begin
      state      <= IDLE;
      off_reg    <= 2'd0;
      size_reg   <= SZ_BYTE;
      read_data  <= 32'd0;
      data_valid <= 1'b0;
      err        <= 1'b0;
      port       <= 1'b0;
      ram_addr   <= '0;
      ram_en     <= 1'b0;
      ram_we     <= 4'd0;
      ram_wdata  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (rw_req) begin
            off_reg   <= address[1:0];
            size_reg  <= size;
            read_data <= 32'd0;
            err       <= 1'b0;
            if (is_misaligned(address[1:0], size)) begin
              err   <= 1'b1;
              state <= DONE;
            end else if (port_hit) begin
              if (rw) port <= write_data[0];
              else    read_data <= {31'b0, port};
              state <= DONE;
            end else if (out_of_range) begin
              state <= DONE;
            end else begin
              ram_en   <= 1'b1;
              ram_addr <= address[ADDR_W+1:2];
              if (rw) begin
                ram_we    <= align_mask;
                ram_wdata <= align_wdata;
                state     <= WR;
              end else begin
                state <= RD_WAIT;
              end
            end
          end
        end
        RD_WAIT: begin
          ram_en <= 1'b0;
          state  <= RD_CAP;
        end
        RD_CAP: begin
          read_data  <= align_rdata;
          data_valid <= 1'b1;
          state      <= DONE;
        end
        WR: begin
          ram_en <= 1'b0;
          ram_we <= 4'd0;
          state  <= DONE;
        end
        DONE: begin
          // First DONE cycle raises data_valid; afterwards wait for the core to let go.
          if (!data_valid) begin
            data_valid <= 1'b1;
          end else if (!rw_req) begin
            data_valid <= 1'b0;
            err        <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lane_ctrl.sv
// Directed bench for mem_lane_ctrl: byte-level memory model plus SRAM stand-in,
// with a per-cycle compare of the completed-access outputs.
module tb_mem_lane_ctrl;
  import mem_pkg::*;

  localparam int          ADDR_W = 11;
  localparam logic [31:0] PORT   = 32'h0000_2000;

  logic              mclk = 1'b0;
  logic              reset = 1'b0;
  logic              rw_req = 1'b0;
  logic              rw = 1'b0;
  logic [31:0]       address = 32'd0;
  logic [1:0]        size = 2'd0;
  logic [31:0]       write_data = 32'd0;
  logic [31:0]       read_data;
  logic              data_valid;
  logic              err;
  logic              port;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_en;
  logic [3:0]        ram_we;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata = 32'd0;

  int tests = 0;
  int fails = 0;

  mem_lane_ctrl #(.ADDR_W(ADDR_W), .PORT_ADDR(PORT)) dut (
    .mclk       (mclk),
    .reset      (reset),
    .rw_req     (rw_req),
    .rw         (rw),
    .address    (address),
    .size       (size),
    .write_data (write_data),
    .read_data  (read_data),
    .data_valid (data_valid),
    .err        (err),
    .port       (port),
    .ram_addr   (ram_addr),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  always #5 mclk = ~mclk;

  // SRAM stand-in: byte-enabled write, registered read
  logic [31:0] sram [0:(1<<ADDR_W)-1];
  always @(posedge mclk) begin
    if (ram_en) begin
      for (int i = 0; i < 4; i++)
        if (ram_we[i]) sram[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
      ram_rdata <= sram[ram_addr];
    end
  end

  // Reference model: flat byte memory and the port bit
  logic [7:0]  mdl [0:(4<<ADDR_W)-1];
  logic        mdl_port = 1'b0;
  logic [31:0] exp_rd = 32'd0;
  logic        exp_err = 1'b0;
  logic        exp_port = 1'b0;
  logic        chk_active = 1'b0;

  int          en_cnt = 0;
  int          we_cnt = 0;
  logic [3:0]  last_we = 4'd0;
  logic [31:0] last_wdata = 32'd0;
  logic [ADDR_W-1:0] last_addr = '0;

  always @(negedge mclk) begin
    if (ram_en) begin
      en_cnt++;
      last_addr = ram_addr;
    end
    if (ram_we != 4'd0) begin
      we_cnt++;
      last_we = ram_we;
      last_wdata = ram_wdata;
    end
  end

  // Completed-access outputs must match the model for every data_valid cycle
  always @(negedge mclk) begin
    if (chk_active && data_valid) begin
      tests++;
      if (read_data !== exp_rd || err !== exp_err || port !== exp_port) begin
        fails++;
        $display("FAIL done_outputs: got rd=%h err=%b port=%b, want rd=%h err=%b port=%b",
                 read_data, err, port, exp_rd, exp_err, exp_port);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, want);
    end
  endtask

  task automatic preload(input int word, input logic [31:0] val);
    sram[word] = val;
    for (int i = 0; i < 4; i++) mdl[4*word + i] = val[8*i +: 8];
  endtask

  task automatic do_req(input string name, input logic [31:0] a, input logic [1:0] sz,
                        input logic w, input logic [31:0] wd, input int hold,
                        input logic [32:0] pin);
    logic [1:0]  off;
    logic        mis, ph, oor, ram;
    logic [31:0] rd, lanes;
    logic [3:0]  mask;
    int          nb, lat, lat_exp;
    off  = a[1:0];
    mis  = (sz == 2'd3) || (sz == 2'd2 && off != 2'd0) || (sz == 2'd1 && off == 2'd3);
    ph   = (a >> 2) == (PORT >> 2);
    oor  = a >= 32'(4 << ADDR_W);
    nb   = 1 << sz;
    rd   = 32'd0;
    mask = 4'd0;
    if (!mis && ph) begin
      if (w) mdl_port = wd[0];
      else   rd = {31'b0, mdl_port};
    end else if (!mis && !oor) begin
      for (int i = 0; i < nb; i++) begin
        if (w) begin
          mdl[a + i] = wd[8*i +: 8];
          mask[off + 2'(i)] = 1'b1;
        end else begin
          rd = rd | (32'(mdl[a + i]) << (8*i));
        end
      end
    end
    ram     = !mis && !ph && !oor;
    lat_exp = ram ? 3 : 2;
    exp_rd  = rd;
    exp_err = mis;
    exp_port = mdl_port;
    if (pin[32]) check({name, "_model_pin"}, w ? {28'd0, mask} : rd, pin[31:0]);

    en_cnt = 0; we_cnt = 0; last_we = 4'd0;
    address = a; size = sz; rw = w; write_data = wd; rw_req = 1'b1;
    chk_active = 1'b1;
    lat = 0;
    while (lat < 20) begin
      @(negedge mclk);
      lat++;
      if (data_valid) break;
    end
    check({name, "_latency"}, 32'(lat), 32'(lat_exp));
    for (int h = 0; h < hold; h++) begin
      @(negedge mclk);
      check({name, "_hold_valid"}, {31'd0, data_valid}, 32'd1);
    end
    rw_req = 1'b0;
    @(negedge mclk);
    chk_active = 1'b0;
    check({name, "_valid_fall"}, {31'd0, data_valid}, 32'd0);
    check({name, "_ram_en_cycles"}, 32'(en_cnt), ram ? 32'd1 : 32'd0);
    check({name, "_ram_we_cycles"}, 32'(we_cnt), (ram && w) ? 32'd1 : 32'd0);
    if (ram) check({name, "_ram_addr"}, 32'(last_addr), 32'(a[ADDR_W+1:2]));
    if (ram && w) begin
      lanes = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
      check({name, "_ram_we"}, {28'd0, last_we}, {28'd0, mask});
      check({name, "_ram_wdata"}, last_wdata & lanes, (wd << (8*off)) & lanes);
    end
    $display("[TB] %s addr=%h size=%0d rw=%b wdata=%h -> exp rd=%h err=%b lat=%0d",
             name, a, sz, w, wd, rd, mis, lat_exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) preload(i, 32'd0);
    preload(4, 32'hDEAD_BEEF);
    preload(0, 32'h1234_5678);

    reset = 1'b0;
    repeat (3) @(negedge mclk);
    check("reset_outputs", {read_data[30:0], data_valid}, 32'd0);
    check("reset_ctrl", {16'd0, ram_addr[7:0], ram_en, ram_we, err, port, read_data[31]}, 32'd0);
    check("reset_wdata", ram_wdata, 32'd0);
    reset = 1'b1;
    @(negedge mclk);

    do_req("LW_10",    32'h10,   SZ_WORD, 1'b0, 32'd0,         0, {1'b1, 32'hDEAD_BEEF});
    check("LW_10_addr_literal", 32'(last_addr), 32'd4);
    do_req("SB_13",    32'h13,   SZ_BYTE, 1'b1, 32'h0000_00AB, 0, {1'b1, 32'h0000_0008});
    check("SB_13_lane_literal", {24'd0, last_wdata[31:24]}, 32'h0000_00AB);
    do_req("LBU_13",   32'h13,   SZ_BYTE, 1'b0, 32'd0,         0, {1'b1, 32'h0000_00AB});
    do_req("LW_10b",   32'h10,   SZ_WORD, 1'b0, 32'd0,         0, {1'b1, 32'hABAD_BEEF});
    do_req("LH_02",    32'h02,   SZ_HALF, 1'b0, 32'd0,         0, {1'b1, 32'h0000_1234});
    do_req("SH_03",    32'h03,   SZ_HALF, 1'b1, 32'h0000_FFFF, 0, {1'b1, 32'h0000_0000});
    do_req("LW_06",    32'h06,   SZ_WORD, 1'b0, 32'd0,         0, {1'b1, 32'h0000_0000});
    do_req("LSZ3_08",  32'h08,   2'd3,    1'b0, 32'd0,         0, {1'b0, 32'd0});
    do_req("SW_PORT",  PORT,     SZ_WORD, 1'b1, 32'h0000_0001, 0, {1'b0, 32'd0});
    do_req("LW_PORT",  PORT,     SZ_WORD, 1'b0, 32'd0,         0, {1'b1, 32'h0000_0001});
    do_req("LW_OOR",   32'h4000, SZ_WORD, 1'b0, 32'd0,         0, {1'b1, 32'h0000_0000});
    do_req("SW_OOR",   32'h4000, SZ_WORD, 1'b1, 32'hFFFF_FFFF, 0, {1'b0, 32'd0});
    do_req("SH_21",    32'h21,   SZ_HALF, 1'b1, 32'h0000_CAFE, 0, {1'b1, 32'h0000_0006});
    do_req("LW_20",    32'h20,   SZ_WORD, 1'b0, 32'd0,         0, {1'b1, 32'h00CA_FE00});
    do_req("SW_1FFC",  32'h1FFC, SZ_WORD, 1'b1, 32'h1122_3344, 0, {1'b1, 32'h0000_000F});
    do_req("LH_1FFE",  32'h1FFE, SZ_HALF, 1'b0, 32'd0,         0, {1'b1, 32'h0000_1122});
    do_req("LB_1FFD",  32'h1FFD, SZ_BYTE, 1'b0, 32'd0,         0, {1'b1, 32'h0000_0033});
    do_req("LW_HOLD",  32'h00,   SZ_WORD, 1'b0, 32'd0,         5, {1'b1, 32'h1234_5678});

    // Reset while the word store has all four lane enables up
    address = 32'h40; size = SZ_WORD; rw = 1'b1; write_data = 32'hFFFF_FFFF; rw_req = 1'b1;
    @(negedge mclk);
    check("RST_WR_we_before", {28'd0, ram_we}, 32'h0000_000F);
    reset = 1'b0;
    @(negedge mclk);
    rw_req = 1'b0;
    check("RST_WR_we_after", {28'd0, ram_we}, 32'd0);
    check("RST_WR_en_after", {31'd0, ram_en}, 32'd0);
    check("RST_WR_valid", {31'd0, data_valid}, 32'd0);
    check("RST_WR_port", {31'd0, port}, 32'd0);
    $display("[TB] RST_WR reset asserted during word store to 0x40");
    mdl_port = 1'b0;
    reset = 1'b1;
    @(negedge mclk);
    check("RST_idle_valid", {31'd0, data_valid}, 32'd0);

    do_req("LW_PORT_R", PORT,  SZ_WORD, 1'b0, 32'd0, 0, {1'b1, 32'h0000_0000});
    do_req("LW_10_R",   32'h10, SZ_WORD, 1'b0, 32'd0, 0, {1'b1, 32'hABAD_BEEF});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
